// File: rtl/uart_frame_pkg.sv
// Shared framing constants and state encodings for the framed UART link.
// START_BYTE/STOP_BYTE are also used by the receiver-side frame parser.
package uart_frame_pkg;

  localparam logic [7:0] START_BYTE = 8'h55;
  localparam logic [7:0] STOP_BYTE  = 8'hAA;

  typedef enum logic [1:0] {
    IDLE,
    START_CH,
    DATA_CH,
    STOP_CH
  } frame_state_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_START,
    CH_DATA,
    CH_STOP
  } char_state_t;

  function automatic logic is_reserved(input logic [7:0] b);
    return (b == START_BYTE) || (b == STOP_BYTE);
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Payload handshake between core logic and the framed UART transmitter.
interface uart_frame_tx_if #(
  parameter int unsigned N_BYTES = 4
);
  logic [8*N_BYTES-1:0] payload;
  logic                 send;
  logic                 ready;
  logic                 busy;
  logic                 frame_done;
  logic                 reserved_hit;

  modport master (
    output payload, send,
    input  ready, busy, frame_done, reserved_hit
  );

  modport slave (
    input  payload, send,
    output ready, busy, frame_done, reserved_hit
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 character serialiser. Accepts a new byte on the last cycle of the
// previous stop bit so characters can be chained with no idle gap.
module uart_tx_byte
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_byte: CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  char_state_t      state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       sh, sh_n;
  logic             tx_n;
  logic             bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CH_IDLE;
      div     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      tx      <= tx_n;
    end
  end

  assign bit_end = (div == DIV_LAST);
  assign ready   = (state == CH_IDLE) || ((state == CH_STOP) && bit_end);

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_idx;
    sh_n    = sh;
    tx_n    = tx;
    done    = 1'b0;
    if (state != CH_IDLE) begin
      div_n = bit_end ? '0 : div + 1'b1;
    end
    case (state)
      CH_IDLE: begin
        if (load) begin
          state_n = CH_START;
          sh_n    = data;
          div_n   = '0;
          tx_n    = 1'b0;
        end
      end
      CH_START: begin
        if (bit_end) begin
          state_n = CH_DATA;
          bit_n   = '0;
          tx_n    = sh[0];
        end
      end
      CH_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = CH_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 1'b1;
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end
      end
      CH_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          // Chained load: next start bit begins on the very next cycle.
          if (load) begin
            state_n = CH_START;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = CH_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = CH_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: START 0x55, N_BYTES payload bytes (LSB first),
// STOP 0xAA, each as a back-to-back 8N1 character.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned N_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_frame_tx_if.slave        bus,
  output logic                  tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned IDX_W = $clog2(N_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

  frame_state_t                fstate, fstate_n;
  logic [IDX_W-1:0]            idx, idx_n, sel;
  logic [N_BYTES-1:0][7:0]     pay_q;
  logic [7:0]                  sel_byte;
  logic [7:0]                  ch_data;
  logic                        ch_load, ch_ready, ch_done;
  logic                        accept, res_any, hit_q, frame_done;

  assign accept = (fstate == IDLE) && bus.send;

  always_comb begin
    res_any = 1'b0;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (is_reserved(bus.payload[8*i +: 8])) res_any = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate <= IDLE;
      idx    <= '0;
      pay_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      fstate <= fstate_n;
      idx    <= idx_n;
      hit_q  <= accept && res_any;
      if (accept) pay_q <= bus.payload;
    end
  end

  // Byte to be queued behind the character currently finishing.
  assign sel = (fstate == START_CH) ? '0 : idx + 1'b1;

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (sel == IDX_W'(i)) sel_byte = pay_q[i];
    end
  end

  always_comb begin
    fstate_n   = fstate;
    idx_n      = idx;
    ch_load    = 1'b0;
    ch_data    = START_BYTE;
    frame_done = 1'b0;
    case (fstate)
      IDLE: begin
        // Load directly from IDLE so tx falls on the cycle after accept.
        if (bus.send) begin
          ch_load  = 1'b1;
          fstate_n = START_CH;
        end
      end
      START_CH: begin
        if (ch_done) begin
          ch_load  = 1'b1;
          ch_data  = sel_byte;
          idx_n    = '0;
          fstate_n = DATA_CH;
        end
      end
      DATA_CH: begin
        if (ch_done) begin
          ch_load = 1'b1;
          if (idx == IDX_LAST) begin
            ch_data  = STOP_BYTE;
            fstate_n = STOP_CH;
          end else begin
            ch_data = sel_byte;
            idx_n   = idx + 1'b1;
          end
        end
      end
      STOP_CH: begin
        if (ch_done) begin
          frame_done = 1'b1;
          fstate_n   = IDLE;
        end
      end
      default: fstate_n = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .data (ch_data),
    .load (ch_load),
    .ready(ch_ready),
    .done (ch_done),
    .tx   (tx)
  );

  assign bus.ready        = (fstate == IDLE);
  assign bus.busy         = (fstate != IDLE);
  assign bus.frame_done   = frame_done;
  assign bus.reserved_hit = hit_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench: stimulus queues expected bytes/flags, a negedge monitor
// decodes tx and checks bytes, character timing and completion pulses.
module tb_uart_frame_tx;
  import uart_frame_pkg::*;

  localparam int unsigned CLK_FREQ  = 1000000;
  localparam int unsigned BAUD      = 100000;
  localparam int unsigned N_BYTES   = 4;
  localparam int unsigned CPB       = CLK_FREQ / BAUD;
  localparam int unsigned FRAME_CYC = (N_BYTES + 2) * 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  uart_frame_tx_if #(.N_BYTES(N_BYTES)) bus ();

  uart_frame_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .N_BYTES (N_BYTES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  logic [7:0] exp_q[$];
  bit         exp_hit_q[$];
  int         exp_frames = 0;
  int         exp_b2b = 0;

  bit         mon_en = 1'b1;
  bit         m_act = 0, hit_pend = 0, hit_exp = 0, ready_pend = 0;
  int         m_cnt = 0, ch_i = 0, f0 = 0, acc_cyc = -100, last_done = -100;
  int         bpos = 0;
  int         done_cnt = 0, acc_cnt = 0, b2b_seen = 0;
  logic [7:0] shv = '0;
  logic [7:0] eb;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      m_act = 0; ch_i = 0; hit_pend = 0; ready_pend = 0;
    end else begin
      if (hit_pend) begin
        hit_pend = 0;
        chk("reserved_hit", bus.reserved_hit, hit_exp);
      end else if (bus.reserved_hit) begin
        chk("reserved_hit_spurious", 1, 0);
      end
      if (bus.send && bus.ready) begin
        acc_cnt++;
        acc_cyc  = cyc;
        hit_pend = 1;
        if (exp_hit_q.size() == 0) begin
          chk("accept_unexpected", 1, 0);
          hit_exp = 0;
        end else hit_exp = exp_hit_q.pop_front();
      end
      if (ready_pend) begin
        ready_pend = 0;
        chk("ready_after_done", bus.ready, 1);
      end
      if (bus.frame_done) begin
        done_cnt++;
        chk("frame_done_time", cyc - f0, FRAME_CYC - 1);
        chk("frame_done_after_stop", ch_i, 0);
        ready_pend = 1;
        last_done  = cyc;
      end
      if (!m_act) begin
        if (tx == 1'b0) begin
          m_act = 1; m_cnt = 0; shv = '0;
          if (ch_i == 0) begin
            f0 = cyc;
            chk("start_latency", cyc - acc_cyc, 1);
            if (cyc == last_done + 2) b2b_seen++;
          end else begin
            chk("char_start", cyc - f0, ch_i * 10 * CPB);
          end
        end
      end else begin
        m_cnt++;
        if (m_cnt >= CPB / 2 && (m_cnt - CPB / 2) % CPB == 0) begin
          bpos = (m_cnt - CPB / 2) / CPB;
          if (bpos == 0) chk("start_bit", tx, 0);
          else if (bpos <= 8) shv[bpos-1] = tx;
          else begin
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) chk("byte_unexpected", 1, 0);
            else begin
              eb = exp_q.pop_front();
              chk("byte", shv, eb);
            end
            m_act = 0;
            ch_i  = (ch_i + 1) % (N_BYTES + 2);
          end
        end
      end
    end
  end

  function automatic bit has_res(input logic [31:0] p);
    for (int i = 0; i < 4; i++) if (is_reserved(p[8*i +: 8])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic expect_frame(input logic [31:0] p);
    exp_q.push_back(START_BYTE);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
    exp_q.push_back(STOP_BYTE);
    exp_hit_q.push_back(has_res(p));
    exp_frames++;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [31:0] p);
    wait_ready();
    repeat (5) @(negedge clk);
    bus.payload = p;
    bus.send    = 1'b1;
    @(posedge clk);
    #1;
    bus.send    = 1'b0;
    bus.payload = ~p;
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int base, n;

    bus.send    = 1'b0;
    bus.payload = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_reserved_hit", bus.reserved_hit, 0);
    rst = 1'b0;

    // Single frame
    expect_frame(32'h04030201);
    send_frame(32'h04030201);
    chk("busy_after_accept", bus.busy, 1);
    wait_ready();

    // Held send: two back-to-back frames
    expect_frame(32'hDEADBEEF);
    expect_frame(32'hDEADBEEF);
    exp_b2b = 1;
    repeat (5) @(negedge clk);
    base = acc_cnt;
    bus.payload = 32'hDEADBEEF;
    bus.send    = 1'b1;
    n = 0;
    while (acc_cnt < base + 2 && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < base + 2) chk("b2b_accept_timeout", acc_cnt - base, 2);
    @(posedge clk);
    #1 bus.send = 1'b0;
    wait_ready();

    // Send while busy is ignored
    expect_frame(32'hCAFE0042);
    send_frame(32'hCAFE0042);
    repeat (200) @(negedge clk);
    chk("busy_mid_frame", bus.busy, 1);
    bus.payload = 32'h11111111;
    bus.send    = 1'b1;
    repeat (3) @(negedge clk);
    bus.send    = 1'b0;
    wait_ready();
    repeat (100) @(negedge clk);

    // Reserved bytes sent verbatim
    expect_frame(32'h00AA5500);
    send_frame(32'h00AA5500);
    wait_ready();

    // Reset during the third character
    p = 32'h44332211;
    exp_q.push_back(START_BYTE);
    exp_q.push_back(p[7:0]);
    exp_hit_q.push_back(1'b0);
    send_frame(p);
    repeat (2 * 10 * CPB + 3 * CPB) @(negedge clk);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    expect_frame(p);
    send_frame(p);
    wait_ready();

    // Loopback payloads free of reserved bytes
    for (int k = 0; k < 20; k++) begin
      p = $urandom;
      for (int i = 0; i < 4; i++) begin
        while (is_reserved(p[8*i +: 8])) p[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      expect_frame(p);
      send_frame(p);
      wait_ready();
    end
    repeat (50) @(negedge clk);

    chk("exp_bytes_left", exp_q.size(), 0);
    chk("exp_accepts_left", exp_hit_q.size(), 0);
    chk("frame_done_count", done_cnt, exp_frames);
    chk("b2b_gap_count", b2b_seen, exp_b2b);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
